fp_acc_seq: RTL
===============

Name: fp_acc_seq

Overview:
- Downstream consumer of the fp multiply sequencer's 4-word product RAM.
- Reads N single-precision words sequentially over a synchronous memory read port.
- Accumulates them through an external fp adder with the same handshake as fp_mult (rst/en/done).
- Presents the final IEEE-754 sum to the next stage or the judge bench.

Parameters:
- N_WORDS, 4, number of words read and accumulated (addresses 0..N_WORDS-1).
- ADDR_W, 2, width of mem_addr; must satisfy 2**ADDR_W >= N_WORDS.
- TIMEOUT, 64, max ADD_RUN cycles waiting for add_done before abort.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin accumulation; sampled in IDLE only.
- mem_addr  out  ADDR_W  read address.
- mem_rd  out  1  read strobe; data valid on mem_data the cycle after.
- mem_data  in  32  read data.
- add_a  out  32  adder operand A (running accumulator).
- add_b  out  32  adder operand B (word just read).
- add_rst  out  1  adder reset pulse.
- add_en  out  1  adder enable.
- add_done  in  1  adder result valid.
- add_z  in  32  adder result.
- sum  out  32  accumulator value; final when done=1.
- busy  out  1  high from start acceptance until completion.
- done  out  1  level; completion flag.
- err  out  1  level; adder timeout occurred.

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, acc=sum=32'h00000000, add_a=add_b=0, add_rst=0, add_en=0, mem_rd=0, mem_addr=0, busy=0, done=0, err=0.
- States: IDLE, RD_REQ, RD_WAIT, ADD_RST, ADD_RUN.
- IDLE: when start=1, clear acc to +0, idx=0, done=0, err=0, busy=1, go to RD_REQ. done/err/sum hold their previous values until start.
- RD_REQ: mem_rd=1, mem_addr=idx for one cycle, then go to RD_WAIT.
- RD_WAIT: mem_rd=0. Latch mem_data into add_b and acc into add_a at the end of the cycle, then go to ADD_RST.
- ADD_RST: add_rst=1, add_en=0 for exactly one cycle, then go to ADD_RUN.
- ADD_RUN:
  - add_rst=0, add_en=1; add_a/add_b held stable.
  - Timeout counter starts at 0 and increments each cycle.
  - On the edge where add_done=1: acc<=add_z, add_en<=0.
    - If idx==N_WORDS-1: done<=1, busy<=0, go to IDLE.
    - Else: idx<=idx+1, go to RD_REQ.
  - If the counter reaches TIMEOUT with add_done still 0: err<=1, done<=1, busy<=0, add_en<=0, go to IDLE; acc keeps its partial value.
- sum is continuously driven from acc.
- Latency: with add_done high in the L-th ADD_RUN cycle, each word costs 3+L cycles. done rises N_WORDS*(3+L) cycles after the edge that samples start.
- start while busy=1 is ignored. start held high in IDLE after completion restarts immediately.
- add_done high outside ADD_RUN is ignored.
- No fp arithmetic inside the block; NaN/Inf pass through the adder unchanged.
- Reset mid-operation aborts with no partial-state retention.

Optional Feature:
- Macro: FP_ACC_ZERO_SKIP_EN.
- Defined: in RD_WAIT, if mem_data[30:0]==0 (+0 or -0), skip ADD_RST/ADD_RUN.
  - idx increments and the FSM goes to RD_REQ.
  - If the skipped word is the last one, go to IDLE with done=1.
  - A skipped word costs 2 cycles.
- Undefined: every word goes through the adder regardless of value.

Test Plan:
- Bench adder model (real add, L=3). Memory = 3F800000, 40000000, 40400000, 40800000; pulse start -> sum=41200000 (10.0), done=1, err=0, done rises exactly 24 cycles after start is sampled; addresses read in order 0,1,2,3.
- Memory = 3F000000 x4 -> sum=40000000. Check add_rst is high exactly one cycle before each add_en rise, and add_a equals the previous add_z.
- Adder model never asserts add_done -> err=1, done=1, busy=0 after TIMEOUT ADD_RUN cycles; sum=00000000.
- Assert rst during the 3rd word's ADD_RUN -> all outputs at reset values immediately. A new start then yields the correct full sum, 41200000.
- Pulse start while busy -> no effect on sequence or result.
- FP_ACC_ZERO_SKIP_EN with memory = 3F800000, 00000000, 80000000, 40000000 -> sum=40400000, only 2 add_en pulses; without the macro, 4 pulses and the same sum.

Source files
------------

// File: rtl/fp_acc_seq.sv
// fp_acc_seq: reads N_WORDS single-precision words from a synchronous RAM and
// accumulates them through an external fp adder using an rst/en/done handshake.
// Optional build macro FP_ACC_ZERO_SKIP_EN: words equal to +0/-0 bypass the adder.
module fp_acc_seq #(
    parameter int unsigned N_WORDS = 4,
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_data,
    output logic [31:0]       add_a,
    output logic [31:0]       add_b,
    output logic              add_rst,
    output logic              add_en,
    input  logic              add_done,
    input  logic [31:0]       add_z,
    output logic [31:0]       sum,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StAddRst,
        StAddRun
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       acc_q, acc_d;
    logic [31:0]       add_a_q, add_a_d;
    logic [31:0]       add_b_q, add_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // State register; reset discards any partial accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            acc_q   <= '0;
            add_a_q <= '0;
            add_b_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: one RAM read plus one adder transaction per word.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StRdReq;
                end
            end
            StRdReq: begin
                state_d = StRdWait;
            end
            StRdWait: begin
                add_a_d = acc_q;
                add_b_d = mem_data;
                state_d = StAddRst;
`ifdef FP_ACC_ZERO_SKIP_EN
                // Adding a signed zero leaves acc unchanged, so skip the adder.
                if (mem_data[30:0] == 31'd0) begin
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StRdReq;
                    end
                end
`endif
            end
            StAddRst: begin
                cnt_d   = '0;
                state_d = StAddRun;
            end
            StAddRun: begin
                if (add_done) begin
                    acc_d = add_z;
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StRdReq;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Adder never answered: abort, keep the partial sum.
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state and registered datapath.
    always_comb begin
        mem_rd   = (state_q == StRdReq);
        mem_addr = idx_q;
        add_rst  = (state_q == StAddRst);
        add_en   = (state_q == StAddRun);
        add_a    = add_a_q;
        add_b    = add_b_q;
        sum      = acc_q;
        busy     = busy_q;
        done     = done_q;
        err      = err_q;
    end

endmodule
